// File: rtl/psum_writeback_pkg.sv
// -----------------------------------------------------------------------------
// psum_writeback_pkg
// Shared definitions for the partial-sum writeback engine:
//   - default lane count, lane width and psum memory address width
//   - FSM state encoding used by psum_writeback
// -----------------------------------------------------------------------------
package psum_writeback_pkg;

  localparam int DEF_COL     = 8;   // output-channel lanes per vector
  localparam int DEF_PSUM_BW = 16;  // signed bits per lane
  localparam int DEF_ADDR_BW = 11;  // psum memory address width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/psum_lane_add.sv
// -----------------------------------------------------------------------------
// psum_lane_add
// One lane of the writeback datapath: adds the captured OFIFO value to the
// value read back from psum memory, or passes the captured value through
// unchanged on a first (overwrite) pass.
//
// Build option:
//   PSUM_WB_SAT_EN  defined   -> sums clamp to the signed lane range
//                   undefined -> sums wrap modulo 2^psum_bw
//
// Ports:
//   i_capt        psum_bw  captured OFIFO lane value (two's complement)
//   i_mem         psum_bw  lane value read from psum memory
//   i_first_pass  1        1 = overwrite (bypass adder), 0 = accumulate
//   o_sum         psum_bw  lane result
// -----------------------------------------------------------------------------
module psum_lane_add
  import psum_writeback_pkg::*;
#(
  parameter int psum_bw = DEF_PSUM_BW
) (
  input  logic [psum_bw-1:0] i_capt,
  input  logic [psum_bw-1:0] i_mem,
  input  logic               i_first_pass,
  output logic [psum_bw-1:0] o_sum
);

  logic [psum_bw-1:0] w_acc;

`ifdef PSUM_WB_SAT_EN
  logic [psum_bw:0] w_wide;

  // Sign-extend by one bit so the true sum is always representable.
  assign w_wide = {i_capt[psum_bw-1], i_capt} + {i_mem[psum_bw-1], i_mem};

  // The sum overflowed exactly when the two top bits disagree; the extra
  // top bit then carries the true sign and picks the clamp direction.
  always_comb begin
    w_acc = w_wide[psum_bw-1:0];
    if (w_wide[psum_bw] != w_wide[psum_bw-1]) begin
      if (w_wide[psum_bw]) begin
        w_acc = {1'b1, {(psum_bw-1){1'b0}}};
      end else begin
        w_acc = {1'b0, {(psum_bw-1){1'b1}}};
      end
    end
  end
`else
  // Plain lane-width addition wraps modulo 2^psum_bw.
  assign w_acc = i_capt + i_mem;
`endif

  assign o_sum = i_first_pass ? i_capt : w_acc;

endmodule

// File: rtl/psum_writeback.sv
// -----------------------------------------------------------------------------
// psum_writeback
// Drains num_vec vectors from the OFIFO into psum memory starting at
// base_addr. Each vector takes READ (pop + memory read), ACCUM (per-lane add
// with the read-back data) and WRITE (store result), so a vector needs at
// least three cycles. On a first pass the read-back data is ignored and the
// OFIFO vector overwrites memory.
//
// Build option:
//   PSUM_WB_SAT_EN  selects saturating lane sums (see psum_lane_add)
//
// Ports:
//   clk           1               rising-edge clock
//   reset         1               asynchronous, active-high reset
//   start         1               start one pass (sampled in IDLE only)
//   first_pass    1               1 = overwrite, 0 = accumulate
//   base_addr     addr_bw         first memory word of the pass
//   num_vec       addr_bw         number of vectors to drain
//   ofifo_valid   1               OFIFO head valid
//   ofifo_output  col*psum_bw     OFIFO head vector
//   ofifo_rd      1               OFIFO pop
//   mem_cen       1               memory enable, active low
//   mem_wen       1               memory write, active low
//   mem_addr      addr_bw         memory address
//   mem_d         col*psum_bw     memory write data
//   mem_q         col*psum_bw     memory read data, one cycle after the read
//   busy          1               pass in progress
//   done          1               one-cycle end-of-pass pulse
// -----------------------------------------------------------------------------
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int col     = DEF_COL,
  parameter int psum_bw = DEF_PSUM_BW,
  parameter int addr_bw = DEF_ADDR_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   first_pass,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [addr_bw-1:0]     num_vec,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_output,
  output logic                   ofifo_rd,
  output logic                   mem_cen,
  output logic                   mem_wen,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [col*psum_bw-1:0] mem_d,
  input  logic [col*psum_bw-1:0] mem_q,
  output logic                   busy,
  output logic                   done
);

  localparam logic [addr_bw-1:0] ADDR_ONE = addr_bw'(1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [addr_bw-1:0]     r_base;
  logic [addr_bw-1:0]     r_num;
  logic [addr_bw-1:0]     r_count;
  logic                   r_first;
  logic [col*psum_bw-1:0] r_capt;
  logic [col*psum_bw-1:0] r_sum;
  logic [col*psum_bw-1:0] w_sum;
  logic [addr_bw-1:0]     w_addr;
  logic                   w_last;

  // Address arithmetic is addr_bw wide, so it wraps past the top word.
  assign w_addr = r_base + r_count;
  assign w_last = ((r_count + ADDR_ONE) == r_num);

  // ---------------------------------------------------------------------------
  // Per-lane adders: no carry ever crosses a lane boundary.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_lane
      psum_lane_add #(
        .psum_bw (psum_bw)
      ) u_lane (
        .i_capt       (r_capt[gi*psum_bw +: psum_bw]),
        .i_mem        (mem_q [gi*psum_bw +: psum_bw]),
        .i_first_pass (r_first),
        .o_sum        (w_sum [gi*psum_bw +: psum_bw])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. Outputs decode from the state register, so an
  // asynchronous reset forces every output to its idle value immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    ofifo_rd     = 1'b0;
    mem_cen      = 1'b1;
    mem_wen      = 1'b1;
    mem_addr     = '0;
    mem_d        = '0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (num_vec == '0) ? ST_DONE : ST_READ;
        end
      end

      ST_READ: begin
        busy = 1'b1;
        // Pop and issue the read together; without a valid head nothing moves.
        if (ofifo_valid) begin
          ofifo_rd     = 1'b1;
          mem_cen      = 1'b0;
          mem_addr     = w_addr;
          w_state_next = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        busy         = 1'b1;
        mem_addr     = w_addr;
        w_state_next = ST_WRITE;
      end

      ST_WRITE: begin
        busy         = 1'b1;
        mem_cen      = 1'b0;
        mem_wen      = 1'b0;
        mem_addr     = w_addr;
        mem_d        = r_sum;
        w_state_next = w_last ? ST_DONE : ST_READ;
      end

      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pass parameters, vector counter and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base  <= '0;
      r_num   <= '0;
      r_count <= '0;
      r_first <= 1'b0;
      r_capt  <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= base_addr;
            r_num   <= num_vec;
            r_first <= first_pass;
            r_count <= '0;
          end
        end
        ST_READ: begin
          if (ofifo_valid) begin
            r_capt <= ofifo_output;
          end
        end
        ST_ACCUM: begin
          // mem_q carries the word requested in READ during this cycle.
          r_sum <= w_sum;
        end
        ST_WRITE: begin
          r_count <= r_count + ADDR_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// -----------------------------------------------------------------------------
// tb_psum_writeback
// Self-checking bench for psum_writeback. A behavioural psum memory and an
// OFIFO queue surround the design; a reference model computes every expected
// memory write from the pass parameters with plain per-lane integer maths.
// Build with +define+PSUM_WB_SAT_EN to expect saturating sums.
// -----------------------------------------------------------------------------
module tb_psum_writeback;

  localparam int COL   = 8;
  localparam int PBW   = 16;
  localparam int ABW   = 11;
  localparam int DEPTH = 1 << ABW;
  localparam int VW    = COL * PBW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           first_pass = 1'b0;
  logic [ABW-1:0] base_addr = '0;
  logic [ABW-1:0] num_vec = '0;
  logic           ofifo_valid;
  logic [VW-1:0]  ofifo_output;
  logic           ofifo_rd;
  logic           mem_cen;
  logic           mem_wen;
  logic [ABW-1:0] mem_addr;
  logic [VW-1:0]  mem_d;
  logic [VW-1:0]  mem_q;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  psum_writeback #(
    .col     (COL),
    .psum_bw (PBW),
    .addr_bw (ABW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .first_pass   (first_pass),
    .base_addr    (base_addr),
    .num_vec      (num_vec),
    .ofifo_valid  (ofifo_valid),
    .ofifo_output (ofifo_output),
    .ofifo_rd     (ofifo_rd),
    .mem_cen      (mem_cen),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_d        (mem_d),
    .mem_q        (mem_q),
    .busy         (busy),
    .done         (done)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ABW-1:0] addr;
    logic [VW-1:0]  data;
  } wr_t;

  logic [VW-1:0] mem     [DEPTH];   // environment memory seen by the DUT
  logic [VW-1:0] ref_mem [DEPTH];   // reference-model memory image
  logic [VW-1:0] fifo_q  [$];       // OFIFO contents
  logic [VW-1:0] vecs    [$];       // vectors for the next pass
  wr_t           exp_wr  [$];       // writes the model expects, in order

  int cyc = 0;
  int vmode = 0;        // 0: valid whenever data queued, 1: random gaps, 2: held low
  int pops, accesses, done_pulses, done_cyc, start_cyc, stray;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural psum memory, one-cycle read latency
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (!mem_cen && mem_wen)  mem_q <= mem[mem_addr];
      if (!mem_cen && !mem_wen) mem[mem_addr] <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // OFIFO driver and output monitor: inputs change on the falling edge, the
  // settled outputs are sampled 1 ns later, ahead of the rising edge that acts.
  // ---------------------------------------------------------------------------
  initial begin
    wr_t e;
    ofifo_valid  = 1'b0;
    ofifo_output = '0;
    forever begin
      @(negedge clk);
      if (fifo_q.size() > 0 && (vmode == 0 || (vmode == 1 && $urandom_range(0, 2) != 0))) begin
        ofifo_valid  = 1'b1;
        ofifo_output = fifo_q[0];
      end else begin
        ofifo_valid  = 1'b0;
        ofifo_output = {4{$urandom}};
      end
      #1;
      if (ofifo_rd) begin
        pops++;
        if (!ofifo_valid || fifo_q.size() == 0) stray++;
        else void'(fifo_q.pop_front());
      end
      if (!mem_cen) accesses++;
      if (!mem_cen && !mem_wen) begin
        if (exp_wr.size() == 0) begin
          stray++;
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_d, e.data);
        end
      end
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [VW-1:0] lane_op(input logic [VW-1:0] old, input logic [VW-1:0] inc,
                                            input bit first);
    logic [VW-1:0] r;
    r = '0;
    for (int l = 0; l < COL; l++) begin
      int a;
      int b;
      int s;
      a = int'($signed(old[l*PBW +: PBW]));
      b = int'($signed(inc[l*PBW +: PBW]));
      s = a + b;
`ifdef PSUM_WB_SAT_EN
      if (s > (1 << (PBW - 1)) - 1) s = (1 << (PBW - 1)) - 1;
      if (s < -(1 << (PBW - 1)))    s = -(1 << (PBW - 1));
`endif
      r[l*PBW +: PBW] = first ? inc[l*PBW +: PBW] : PBW'(s);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] fill(input int val);
    logic [VW-1:0] v;
    for (int l = 0; l < COL; l++) v[l*PBW +: PBW] = PBW'(val);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < COL; l++) begin
      case ($urandom_range(0, 3))
        0:       v[l*PBW +: PBW] = 16'h7FFF;
        1:       v[l*PBW +: PBW] = 16'h8000;
        default: v[l*PBW +: PBW] = PBW'($urandom);
      endcase
    end
    return v;
  endfunction

  // Queue the pass into the model and the OFIFO, then pulse start.
  task automatic begin_pass(input int base, input int n, input bit first);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % DEPTH;
      ref_mem[a] = lane_op(ref_mem[a], vecs[i], first);
      exp_wr.push_back('{addr: ABW'(a), data: ref_mem[a]});
      fifo_q.push_back(vecs[i]);
    end
    pops = 0; accesses = 0; done_pulses = 0; stray = 0; done_cyc = -1;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = ABW'(base);
    num_vec    = ABW'(n);
    first_pass = first;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("busy_run", busy, (n > 0));
  endtask

  // Wait for done while throwing junk starts at the busy design.
  task automatic finish_pass(input int base, input int n, input bit first, input int exp_lat);
    int t;
    t = 0;
    while (done_pulses == 0 && t < 400) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      base_addr  = ABW'($urandom);
      num_vec    = ABW'($urandom);
      first_pass = $urandom_range(0, 1);
      #2;
      t++;
    end
    start = 1'b0;
    check("done_seen", (done_pulses > 0), 1);
    if (exp_lat >= 0) check("latency", done_cyc - start_cyc, exp_lat);
    @(negedge clk);
    #2;
    check("done_width", done_pulses, 1);
    check("busy_idle", busy, 0);
    check("pops", pops, n);
    check("mem_access", accesses, 2 * n);
    check("writes_left", exp_wr.size(), 0);
    check("protocol", stray, 0);
    $display("[TB] pass base=%0d n=%0d first=%0d latency=%0d pops=%0d", base, n, first,
             done_cyc - start_cyc, pops);
    fifo_q.delete();
    exp_wr.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd"},   ofifo_rd, 0);
    check({tag, "_cen"},  mem_cen, 1);
    check({tag, "_wen"},  mem_wen, 1);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_d"},    mem_d, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [VW-1:0] saved [3];
    logic [VW-1:0] w;
    int base;
    int n;
    bit first;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset values
    @(negedge clk);
    #2;
    check_idle_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // Overwrite pass of two vectors, no stalls
    vecs.delete(); vecs.push_back(fill(3)); vecs.push_back(fill(7));
    begin_pass(5, 2, 1'b1);
    finish_pass(5, 2, 1'b1, 7);

    // Accumulate 100 + (-30)
    vecs.delete(); vecs.push_back(fill(100));
    begin_pass(20, 1, 1'b1);
    finish_pass(20, 1, 1'b1, 4);
    vecs.delete(); vecs.push_back(fill(-30));
    begin_pass(20, 1, 1'b0);
    finish_pass(20, 1, 1'b0, 4);
    w = mem[20];
    check("accum_70", w[PBW-1:0], 70);

    // OFIFO empty for the first four READ cycles
    vmode = 2;
    vecs.delete(); vecs.push_back(rand_vec()); vecs.push_back(rand_vec());
    begin_pass(40, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #2;
      end
      check("stall_rd", ofifo_rd, 0);
      check("stall_cen", mem_cen, 1);
      check("stall_busy", busy, 1);
    end
    vmode = 0;
    finish_pass(40, 2, 1'b0, 11);

    // Address wrap past the top word
    vecs.delete(); vecs.push_back(rand_vec()); vecs.push_back(rand_vec());
    begin_pass(DEPTH - 1, 2, 1'b0);
    finish_pass(DEPTH - 1, 2, 1'b0, 7);

    // Lane overflow 32767 + 1
    vecs.delete(); vecs.push_back(fill(32767));
    begin_pass(300, 1, 1'b1);
    finish_pass(300, 1, 1'b1, 4);
    vecs.delete(); vecs.push_back(fill(1));
    begin_pass(300, 1, 1'b0);
    finish_pass(300, 1, 1'b0, 4);
    w = mem[300];
`ifdef PSUM_WB_SAT_EN
    check("ovf_lane", w[PBW-1:0], 16'h7FFF);
`else
    check("ovf_lane", w[PBW-1:0], 16'h8000);
`endif

    // Empty pass
    vecs.delete();
    begin_pass(77, 0, 1'b0);
    finish_pass(77, 0, 1'b0, 1);

    // Randomized passes
    for (int p = 0; p < 10; p++) begin
      base  = $urandom_range(0, DEPTH - 1);
      n     = $urandom_range(1, 6);
      first = $urandom_range(0, 1);
      vmode = $urandom_range(0, 1);
      vecs.delete();
      for (int i = 0; i < n; i++) vecs.push_back(rand_vec());
      begin_pass(base, n, first);
      finish_pass(base, n, first, (vmode == 0) ? 3 * n + 1 : -1);
    end
    vmode = 0;

    // Reset while in ACCUM of the first vector
    for (int i = 0; i < 3; i++) saved[i] = ref_mem[100 + i];
    vecs.delete();
    for (int i = 0; i < 3; i++) vecs.push_back(rand_vec());
    begin_pass(100, 3, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    exp_wr.delete();
    fifo_q.delete();
    for (int i = 0; i < 3; i++) ref_mem[100 + i] = saved[i];
    #2;
    check_idle_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("midrst_nowrite", stray, 0);
    check("midrst_nodone", done_pulses, 0);
    w = mem[100];
    check("midrst_mem", w, saved[0]);
    $display("[TB] reset mid-pass pops=%0d done=%0d", pops, done_pulses);

    vecs.delete(); vecs.push_back(rand_vec()); vecs.push_back(rand_vec());
    begin_pass(100, 2, 1'b0);
    finish_pass(100, 2, 1'b0, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
